seven_segment_scan: RTL and testbench
=====================================

// Module: seven_segment_scan
// PURPOSE
//   Downstream display stage for the stopwatch: consumes the four BCD digit buses and drives a
//   4-digit, common-anode, time-multiplexed seven-segment display (active-low anodes/segments).
//   Scans one digit per refresh period, captures digits in a tear-free frame snapshot,
//   optionally blanks leading zeros, and drives per-digit decimal points.
// PARAMETERS
//   REFRESH_COUNT  100000  clk cycles per digit slot (>=1); 100 MHz -> 1 ms/digit, 250 Hz frame
//   CNT_W          $clog2(REFRESH_COUNT+1)  derived width of refresh counter (localparam)
// PORTS
//   clk       in   1  system clock, single domain
//   reset     in   1  synchronous, active-low reset (0 = reset), sampled on rising clk
//   enable    in   1  1 = display on; 0 = all anodes off, scanning continues
//   blank_en  in   1  1 = suppress leading zeros on digit3..digit1
//   dp_mask   in   4  bit i = light decimal point on digit i
//   digit0    in   4  BCD, least significant (rightmost)
//   digit1    in   4  BCD
//   digit2    in   4  BCD
//   digit3    in   4  BCD, most significant (leftmost)
//   anode     out  4  active-low digit select, one-hot-low; bit i = digit i
//   segment   out  7  active-low; segment[0]=a ... segment[6]=g
//   dp        out  1  active-low decimal point for currently selected digit
// BEHAVIOUR
// - Reset (reset==0 at clk edge): refresh counter=0, scan index=0, snapshot=0, anode=4'b1111,
//   segment=7'h7F, dp=1. Reset mid-scan takes effect on that edge; scan restarts at index 0.
// - Refresh counter counts 0..REFRESH_COUNT-1 then wraps to 0; tick asserted in the cycle the
//   counter holds REFRESH_COUNT-1. REFRESH_COUNT==1 -> tick every cycle.
// - Scan index (2 bit) advances on tick: 0->1->2->3->0.
// - Snapshot: digit0..3, dp_mask, blank_en loaded into shadow regs on tick when index==3 (frame
//   boundary), so every frame shows one coherent value. Input changes mid-frame are invisible
//   until the next frame; worst-case latency input->display = 4*REFRESH_COUNT+1 cycles.
// - Outputs are registered: anode/segment/dp reflect the new index one cycle after the tick edge.
// - Decode (snapshot BCD -> segment, active-low): 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19
//   5=7'h12 6=7'h02 7=7'h78 8=7'h00 9=7'h10; 10..15 -> dash 7'h3F (g only).
// - Leading-zero blanking (snapshot blank_en==1): d3 blank if d3==0; d2 blank if d3 blank && d2==0;
//   d1 blank if d2 blank && d1==0; d0 never blanked. Blanked slot: anode bit high, segment=7'h7F,
//   dp=1 (dp_mask ignored for blanked digits).
// - enable==0: anode=4'b1111, segment=7'h7F, dp=1 from next edge; counter/index/snapshot keep
//   running so re-enable resumes mid-frame without glitch beyond one slot.
// - Never more than one anode low in any cycle; no X on outputs after first reset edge.
// STRUCTURE
// - Package seg7_pkg: SEG_DIGIT[0:9] constants, SEG_DASH, SEG_OFF, function seg7_decode(logic[3:0]).
// - Sub-module scan_divider #(REFRESH_COUNT): refresh counter, outputs one-cycle tick.
// - Top: scan index, snapshot regs, blanking chain (combinational), output regs.
// TESTING
// 1. Hold reset=0 5 cycles, digits=4'h9 -> anode=1111, segment=7F, dp=1 every cycle.
// 2. REFRESH_COUNT=4, d3..d0=4,3,2,1, blank_en=0 -> after first frame, anode 1110/1101/1011/0111
//    each for 4 cycles, segment 79/24/30/19 respectively.
// 3. blank_en=1, d3..d0=0,0,0,7 -> only anode 1110 lit (seg 78), other slots anode high;
//    all zeros -> only digit0 lit showing 40.
// 4. Change digit0 1->5 while index==1 -> digit0 slot shows 79 until after index 3->0 tick, then 12.
// 5. digit2=4'hC, dp_mask=4'b0100 -> digit2 slot segment=3F, dp=0; other slots dp=1.
// 6. Assert reset=0 while index==2, release -> index 0 restarts, snapshot 0, REFRESH_COUNT=1
//    variant scans one digit per cycle; assertion: $onehot0(~anode) always.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Segment patterns are active-low, bit 0 = a ... bit 6 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef struct packed {
        logic [3:0][3:0] digit;
        logic [3:0]      dp_mask;
        logic            blank_en;
    } snap_t;

    // Non-BCD codes show a dash so a corrupted digit is visible rather than dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_DIGIT[0];
            4'd1:    return SEG_DIGIT[1];
            4'd2:    return SEG_DIGIT[2];
            4'd3:    return SEG_DIGIT[3];
            4'd4:    return SEG_DIGIT[4];
            4'd5:    return SEG_DIGIT[5];
            4'd6:    return SEG_DIGIT[6];
            4'd7:    return SEG_DIGIT[7];
            4'd8:    return SEG_DIGIT[8];
            4'd9:    return SEG_DIGIT[9];
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Refresh counter: counts 0..REFRESH_COUNT-1 and flags the last cycle of each slot.
module scan_divider #(
    parameter int REFRESH_COUNT = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CNT_W = $clog2(REFRESH_COUNT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(REFRESH_COUNT - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Four-digit common-anode display scanner with frame snapshot, leading-zero
// blanking and per-digit decimal points. All outputs are registered.
module seven_segment_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_COUNT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       blank_en,
    input  logic [3:0] dp_mask,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] anode,
    output logic [6:0] segment,
    output logic       dp
);
    logic       tick;
    logic [1:0] idx_q, idx_d;
    snap_t      snap_q, snap_d;
    logic [3:0] blank;
    logic [3:0] anode_q, anode_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    scan_divider #(.REFRESH_COUNT(REFRESH_COUNT)) u_div (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    // Snapshot only at the frame boundary so one frame never mixes two values.
    always_comb begin
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        snap_d = snap_q;
        if (tick && idx_q == 2'd3) begin
            snap_d.digit    = {digit3, digit2, digit1, digit0};
            snap_d.dp_mask  = dp_mask;
            snap_d.blank_en = blank_en;
        end
    end

    always_comb begin
        blank[3] = snap_q.blank_en && (snap_q.digit[3] == 4'd0);
        blank[2] = blank[3] && (snap_q.digit[2] == 4'd0);
        blank[1] = blank[2] && (snap_q.digit[1] == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        anode_d = 4'b1111;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (enable && !blank[idx_q]) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = seg7_decode(snap_q.digit[idx_q]);
            dp_d           = ~snap_q.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q   <= 2'd0;
            snap_q  <= '0;
            anode_q <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anode   = anode_q;
    assign segment = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench: a slot-arithmetic reference model predicts every output
// cycle for a REFRESH_COUNT=4 and a REFRESH_COUNT=1 instance.
module tb_seven_segment_scan;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    typedef struct packed {
        logic [15:0] dg;
        logic [3:0]  dpm;
        logic        be;
    } msnap_t;

    localparam logic [6:0] SEGTAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic       clk = 1'b0;
    logic       reset, enable, blank_en;
    logic [3:0] dp_mask, digit0, digit1, digit2, digit3;
    logic [3:0] anode4, anode1;
    logic [6:0] segment4, segment1;
    logic       dp4, dp1;

    int n_chk  = 0;
    int n_fail = 0;
    out_t q4[$];
    out_t q1[$];

    always #5 clk = ~clk;

    seven_segment_scan #(.REFRESH_COUNT(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .blank_en(blank_en),
        .dp_mask(dp_mask), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3),
        .anode(anode4), .segment(segment4), .dp(dp4)
    );

    seven_segment_scan #(.REFRESH_COUNT(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .blank_en(blank_en),
        .dp_mask(dp_mask), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3),
        .anode(anode1), .segment(segment1), .dp(dp1)
    );

    // Output after edge k (k edges since reset released): slot = (k/rc)%4,
    // shown from the snapshot taken at the previous frame end.
    function automatic out_t model(input int rc, input int k, input msnap_t s, input logic en);
        out_t o;
        int   slot;
        int   lead;
        logic [3:0] d;
        o.an  = 4'hF;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        if (!en) return o;
        slot = (k / rc) % 4;
        lead = 0;
        if (s.be)
            for (int i = 3; i >= 1; i--)
                if (lead == 3 - i && s.dg[i*4 +: 4] == 4'd0) lead++;
        if (slot >= 4 - lead) return o;
        d     = s.dg[slot*4 +: 4];
        o.an  = ~(4'b0001 << slot);
        o.seg = SEGTAB[d];
        o.dp  = ~s.dpm[slot];
        return o;
    endfunction

    task automatic cmp(input string name, input out_t e, input out_t a);
        n_chk++;
        if (a.an !== e.an || a.seg !== e.seg || a.dp !== e.dp) begin
            n_fail++;
            $display("FAIL %s t=%0t got anode=%b seg=%h dp=%b expected anode=%b seg=%h dp=%b",
                     name, $time, a.an, a.seg, a.dp, e.an, e.seg, e.dp);
        end
    endtask

    task automatic onehot_chk(input string name, input logic [3:0] an);
        n_chk++;
        if (!$onehot0(~an)) begin
            n_fail++;
            $display("FAIL %s onehot t=%0t anode=%b expected at most one low bit", name, $time, an);
        end
    endtask

    // Reference model: predicts the registered output of each edge.
    initial begin : model_proc
        int     k4, k1;
        msnap_t s4, s1, cur;
        out_t   off;
        off.an = 4'hF; off.seg = 7'h7F; off.dp = 1'b1;
        k4 = 0; k1 = 0; s4 = '0; s1 = '0;
        forever begin
            @(posedge clk);
            cur = {digit3, digit2, digit1, digit0, dp_mask, blank_en};
            if (!reset) begin
                k4 = 0; k1 = 0; s4 = '0; s1 = '0;
                q4.push_back(off);
                q1.push_back(off);
            end else begin
                q4.push_back(model(4, k4, s4, enable));
                q1.push_back(model(1, k1, s1, enable));
                if (k4 % 16 == 15) s4 = cur;
                if (k1 % 4 == 3)   s1 = cur;
                k4++;
                k1++;
            end
        end
    end

    // Monitor: pops one expectation per DUT per edge, away from the edge.
    initial begin : monitor_proc
        out_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rc4 queue empty t=%0t expected an entry", $time);
            end else begin
                e = q4.pop_front();
                a.an = anode4; a.seg = segment4; a.dp = dp4;
                cmp("rc4", e, a);
            end
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rc1 queue empty t=%0t expected an entry", $time);
            end else begin
                e = q1.pop_front();
                a.an = anode1; a.seg = segment1; a.dp = dp1;
                cmp("rc1", e, a);
            end
            onehot_chk("rc4", anode4);
            onehot_chk("rc1", anode1);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    endtask

    function automatic logic [3:0] rnd_digit();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin : stim
        reset = 1'b0; enable = 1'b1; blank_en = 1'b0; dp_mask = 4'h0;
        set_digits(4'h9, 4'h9, 4'h9, 4'h9);
        run(5);
        reset = 1'b1;
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        run(40);
        blank_en = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        run(40);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        run(40);
        blank_en = 1'b0;
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        run(21);
        digit0 = 4'd5;
        run(30);
        set_digits(4'd1, 4'hC, 4'd6, 4'd8);
        dp_mask = 4'b0100;
        run(40);
        run(9);
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        run(40);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                set_digits(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
            if ($urandom_range(0, 31) == 0) blank_en = ~blank_en;
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        reset = 1'b1;
        run(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
